// File: rtl/addsub_pkg.sv
// Package: addsub_pkg
// Shared constants and types for the registered adder/subtractor front end.
//   ADDSUB_WIDTH   default datapath width
//   state_t        handshake FSM states (IDLE, CALC, DONE)
//   OP_ADD/OP_SUB  encodings of the op_sub request bit
//   SAT_POS/SAT_NEG saturation limits at the default width
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [ADDSUB_WIDTH-1:0] SAT_POS = {1'b0, {(ADDSUB_WIDTH-1){1'b1}}};
    localparam logic [ADDSUB_WIDTH-1:0] SAT_NEG = {1'b1, {(ADDSUB_WIDTH-1){1'b0}}};

endpackage

// File: rtl/addsub16_core.sv
// Module: addsub16_core
// Combinational ripple-carry adder/subtractor. For subtraction B is inverted
// and the carry-in is 1.
//   a, b      operands
//   sub       1 = a - b, 0 = a + b
//   raw_sum   low WIDTH bits of the result
//   outc      carry out of the msb stage
//   overflow  signed overflow (uses B after conditional inversion)
module addsub16_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] raw_sum,
    output logic             outc,
    output logic             overflow
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   carry;

    always_comb begin
        bx       = b ^ {WIDTH{sub}};
        carry    = '0;
        carry[0] = sub;
        raw_sum  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            raw_sum[i]   = a[i] ^ bx[i] ^ carry[i];
            carry[i+1]   = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
        end
        outc     = carry[WIDTH];
        overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Module: addsub_accumulator
// Registered, handshaked front end for the adder/subtractor core with an
// optional running-accumulator operand.
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand request handshake (ready only in IDLE)
//   op_sub               0 = A+B, 1 = A-B
//   acc_sel              operand A taken from the accumulator
//   acc_clr              synchronous accumulator clear, any state
//   input1, input2       operands A and B
//   out_valid/out_ready  result handshake; result held until accepted
//   sum, outc, borrow, overflow  registered result and flags
// Build option: define ADDSUB_SAT_EN to saturate sum on signed overflow.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             acc_sel,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             outc,
    output logic             borrow,
    output logic             overflow
);

    state_t state, state_d;

    logic [WIDTH-1:0] opa, opb, acc;
    logic             sub_q, asel_q;

    logic [WIDTH-1:0] core_sum, result;
    logic             core_outc, core_ovf;

    addsub16_core #(.WIDTH(WIDTH)) u_core (
        .a        (opa),
        .b        (opb),
        .sub      (sub_q == OP_SUB),
        .raw_sum  (core_sum),
        .outc     (core_outc),
        .overflow (core_ovf)
    );

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};

    // Overflow direction follows the sign of A (A and B' share that sign).
    always_comb begin
        result = core_sum;
        if (core_ovf) result = opa[WIDTH-1] ? SAT_NEG_W : SAT_POS_W;
    end
`else
    always_comb begin
        result = core_sum;
    end
`endif

    assign in_ready = (state == IDLE);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            sub_q     <= OP_ADD;
            asel_q    <= 1'b0;
            sum       <= '0;
            outc      <= 1'b0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (in_valid) begin
                    // A clear in the accept cycle also zeroes the sampled accumulator.
                    opa    <= acc_sel ? (acc_clr ? '0 : acc) : input1;
                    opb    <= input2;
                    sub_q  <= op_sub;
                    asel_q <= acc_sel;
                end
                CALC: begin
                    sum       <= result;
                    outc      <= core_outc;
                    borrow    <= (sub_q == OP_SUB) & ~core_outc;
                    overflow  <= core_ovf;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (state == DONE && out_ready && asel_q) begin
            acc <= sum;
        end
    end

endmodule

// File: tb/tb_addsub_accumulator.sv
module tb_addsub_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op_sub, acc_sel, acc_clr;
    logic [15:0] input1, input2, sum;
    logic        out_valid, out_ready, outc, borrow, overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] acc_m;
    logic [15:0] last_sum;
    logic        last_outc, last_borrow, last_ovf;

    always #5 clk = ~clk;

    addsub_accumulator #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .acc_sel   (acc_sel),
        .acc_clr   (acc_clr),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .outc      (outc),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference arithmetic from plain integer rules.
    task automatic model(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] s, output logic c, output logic br, output logic ov);
        int unsigned ua, ub;
        int sa, sb, r;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        if (sub) begin
            s = 16'(ua - ub);
            c = (ua >= ub);
            r = sa - sb;
        end else begin
            s = 16'(ua + ub);
            c = ((ua + ub) > 32'd65535);
            r = sa + sb;
        end
        ov = (r > 32767) || (r < -32768);
        br = sub & ~c;
`ifdef ADDSUB_SAT_EN
        if (ov) s = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
    endtask

    task automatic do_op(input logic sub, input logic asel, input logic clr,
                         input logic [15:0] a, input logic [15:0] b,
                         input int hold, input logic done_clr);
        logic [15:0] opa, es;
        logic ec, eb, eo;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        opa = asel ? (clr ? 16'h0 : acc_m) : a;
        if (clr) acc_m = 16'h0;
        model(sub, opa, b, es, ec, eb, eo);
        in_valid = 1; op_sub = sub; acc_sel = asel; acc_clr = clr; input1 = a; input2 = b;
        @(negedge clk);
        in_valid = 0; acc_clr = 0; input1 = 16'($urandom); input2 = 16'($urandom);
        chk("calc_valid", out_valid, 0);
        chk("calc_ready", in_ready, 0);
        @(negedge clk);
        chk("done_valid", out_valid, 1);
        chk("sum", sum, es);
        chk("outc", outc, ec);
        chk("borrow", borrow, eb);
        chk("overflow", overflow, eo);
        last_sum = sum; last_outc = outc; last_borrow = borrow; last_ovf = overflow;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; input1 = 16'($urandom); input2 = 16'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, es);
            chk("hold_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1; acc_clr = done_clr;
        @(negedge clk);
        out_ready = 0; acc_clr = 0;
        chk("release_ready", in_ready, 1);
        chk("release_valid", out_valid, 0);
        if (done_clr) acc_m = 16'h0;
        else if (asel) acc_m = es;
    endtask

    task automatic reset_check(input string tag);
        rst_n = 0;
        #1;
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_flags"}, {outc, borrow, overflow}, 0);
        chk({tag, "_ready"}, in_ready, 1);
        acc_m = 16'h0;
        in_valid = 0; out_ready = 0; acc_clr = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; op_sub = 0; acc_sel = 0; acc_clr = 0;
        input1 = 0; input2 = 0; out_ready = 0; acc_m = 16'h0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {outc, borrow, overflow}, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;

        // 1: signed overflow on add
        do_op(0, 0, 0, 16'h7FFF, 16'h0001, 0, 0);
`ifdef ADDSUB_SAT_EN
        chk("t1_sum", last_sum, 16'h7FFF);
`else
        chk("t1_sum", last_sum, 16'h8000);
`endif
        chk("t1_flags", {last_ovf, last_outc, last_borrow}, 3'b100);

        // 2: subtraction with and without borrow
        do_op(1, 0, 0, 16'h0003, 16'h0005, 0, 0);
        chk("t2a_sum", last_sum, 16'hFFFE);
        chk("t2a_flags", {last_ovf, last_outc, last_borrow}, 3'b001);
        do_op(1, 0, 0, 16'h0005, 16'h0003, 0, 0);
        chk("t2b_sum", last_sum, 16'h0002);
        chk("t2b_flags", {last_outc, last_borrow}, 2'b10);

        // 3: back-pressure for 5 cycles with in_valid held high
        do_op(0, 0, 0, 16'h1234, 16'h1111, 5, 0);

        // 4: accumulate
        do_op(0, 1, 1, 16'hAAAA, 16'h0010, 0, 0);
        chk("t4_s1", last_sum, 16'h0010);
        do_op(0, 1, 0, 16'hAAAA, 16'h0010, 0, 0);
        chk("t4_s2", last_sum, 16'h0020);
        do_op(0, 1, 0, 16'hAAAA, 16'h0010, 0, 0);
        chk("t4_s3", last_sum, 16'h0030);
        do_op(1, 1, 0, 16'hAAAA, 16'h0040, 0, 0);
        chk("t4_sub", last_sum, 16'hFFF0);
        chk("t4_borrow", last_borrow, 1);

        // 5: clear takes priority over the DONE accumulator write
        do_op(0, 1, 0, 16'h0, 16'h0100, 0, 1);
        do_op(0, 1, 0, 16'h5555, 16'h0001, 0, 0);
        chk("t5_sum", last_sum, 16'h0001);

        // 6: reset during CALC, then during DONE
        do_op(0, 1, 0, 16'h0, 16'h0007, 0, 0);
        @(negedge clk);
        in_valid = 1; op_sub = 0; acc_sel = 0; input1 = 16'h4321; input2 = 16'h1111;
        @(negedge clk);
        in_valid = 0;
        reset_check("rst_calc");
        do_op(0, 1, 0, 16'h9999, 16'h0001, 0, 0);
        chk("t6_acc", last_sum, 16'h0001);
        @(negedge clk);
        in_valid = 1; op_sub = 1; acc_sel = 0; input1 = 16'h0001; input2 = 16'h0002;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("t6_done_valid", out_valid, 1);
        reset_check("rst_done");
        do_op(0, 1, 0, 16'h0, 16'h0001, 0, 0);
        chk("t6b_acc", last_sum, 16'h0001);

        // random operations against the model, including accumulator chains
        for (int n = 0; n < 40; n++) begin
            do_op(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                  16'($urandom), 16'($urandom), $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0));
        end
        chk("final_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
